mips_ctrl_fsm: RTL and testbench

Control sequencer for the single-cycle MIPS datapath. Decodes the current `instruction` into the 12-bit datapath control word and gates PC advance and register write-back (`pc_en`, `rf_we`). Adds a variable-latency data-memory handshake with timeout and a sticky halt on illegal opcodes. Sits between instruction memory, data memory and `datapath`, replacing hand-driven control.

---
 rtl/mips_ctrl_pkg.sv | 88 ++++++++
 rtl/mips_decoder.sv | 107 ++++++++++
 rtl/mips_ctrl_fsm.sv | 132 +++++++++++++
 tb/tb_mips_ctrl_fsm.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the MIPS control sequencer: opcode/funct values,
// datapath select encodings, the packed control word and the FSM states.
package mips_ctrl_pkg;

    // Primary opcodes (instruction[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (instruction[5:0])
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_NOR = 4'd5,
        ALU_SLT = 4'd6,
        ALU_SLL = 4'd7,
        ALU_SRL = 4'd8
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JUMP   = 2'b10,
        PC_REG    = 2'b11
    } sel_pc_e;

    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_DMEM = 2'b01,
        RES_PC4  = 2'b10
    } sel_result_e;

    typedef enum logic [1:0] {
        WA_RT  = 2'b00,
        WA_RD  = 2'b01,
        WA_R31 = 2'b10
    } sel_wa_e;

    // 12-bit datapath control word, MSB first
    typedef struct packed {
        logic        rf_we;
        sel_wa_e     sel_wa;
        logic        sel_alu_b;
        sel_result_e sel_result;
        sel_pc_e     sel_pc;
        alu_ctrl_e   alu_ctrl;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{
        rf_we:      1'b0,
        sel_wa:     WA_RT,
        sel_alu_b:  1'b0,
        sel_result: RES_ALU,
        sel_pc:     PC_PLUS4,
        alu_ctrl:   ALU_ADD
    };

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALT     = 2'd2
    } state_e;

endpackage

// File: rtl/mips_decoder.sv
// Purely combinational instruction decoder: instruction + zero flag to
// control word, memory-access class and illegal-instruction flag.
module mips_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [31:0] instruction,
    input  logic        zero,
    output ctrl_t       ctrl,
    output logic        is_mem,
    output logic        is_store,
    output logic        illegal
);

    logic [5:0] w_op;
    logic [5:0] w_funct;
    logic       w_unused;

    assign w_op     = instruction[31:26];
    assign w_funct  = instruction[5:0];
    // Register/immediate fields are consumed by the datapath, not here
    assign w_unused = ^instruction[25:6];

    // Decode opcode/funct into the control word; anything unknown is illegal
    always_comb begin
        ctrl     = CTRL_NOP;
        is_mem   = 1'b0;
        is_store = 1'b0;
        illegal  = 1'b0;
        case (w_op)
            OP_RTYPE: begin
                ctrl.rf_we  = 1'b1;
                ctrl.sel_wa = WA_RD;
                case (w_funct)
                    FN_ADD, FN_ADDU: ctrl.alu_ctrl = ALU_ADD;
                    FN_SUB:          ctrl.alu_ctrl = ALU_SUB;
                    FN_AND:          ctrl.alu_ctrl = ALU_AND;
                    FN_OR:           ctrl.alu_ctrl = ALU_OR;
                    FN_XOR:          ctrl.alu_ctrl = ALU_XOR;
                    FN_NOR:          ctrl.alu_ctrl = ALU_NOR;
                    FN_SLT:          ctrl.alu_ctrl = ALU_SLT;
                    FN_SLL:          ctrl.alu_ctrl = ALU_SLL;
                    FN_SRL:          ctrl.alu_ctrl = ALU_SRL;
                    FN_JR: begin
                        ctrl.rf_we  = 1'b0;
                        ctrl.sel_wa = WA_RT;
                        ctrl.sel_pc = PC_REG;
                    end
                    default: begin
                        ctrl    = CTRL_NOP;
                        illegal = 1'b1;
                    end
                endcase
            end
            OP_LW: begin
                ctrl.rf_we      = 1'b1;
                ctrl.sel_alu_b  = 1'b1;
                ctrl.sel_result = RES_DMEM;
                is_mem          = 1'b1;
            end
            OP_SW: begin
                ctrl.sel_alu_b = 1'b1;
                is_mem         = 1'b1;
                is_store       = 1'b1;
            end
            OP_BEQ: begin
                ctrl.alu_ctrl = ALU_SUB;
                if (zero) ctrl.sel_pc = PC_BRANCH;
            end
            OP_BNE: begin
                ctrl.alu_ctrl = ALU_SUB;
                if (!zero) ctrl.sel_pc = PC_BRANCH;
            end
            OP_ADDI, OP_ADDIU: begin
                ctrl.rf_we     = 1'b1;
                ctrl.sel_alu_b = 1'b1;
            end
            OP_ANDI: begin
                ctrl.rf_we     = 1'b1;
                ctrl.sel_alu_b = 1'b1;
                ctrl.alu_ctrl  = ALU_AND;
            end
            OP_ORI: begin
                ctrl.rf_we     = 1'b1;
                ctrl.sel_alu_b = 1'b1;
                ctrl.alu_ctrl  = ALU_OR;
            end
            OP_SLTI: begin
                ctrl.rf_we     = 1'b1;
                ctrl.sel_alu_b = 1'b1;
                ctrl.alu_ctrl  = ALU_SLT;
            end
            OP_J: begin
                ctrl.sel_pc = PC_JUMP;
            end
            OP_JAL: begin
                ctrl.rf_we      = 1'b1;
                ctrl.sel_wa     = WA_R31;
                ctrl.sel_result = RES_PC4;
                ctrl.sel_pc     = PC_JUMP;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mips_ctrl_fsm.sv
// Control sequencer: gates commit of decoded instructions, runs the
// data-memory handshake with timeout, and halts on illegal opcodes.
module mips_ctrl_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      instruction,
    input  logic             imem_valid,
    input  logic             zero,
    input  logic             dmem_ack,
    output logic [11:0]      ctrl,
    output logic             pc_en,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             halted,
    output logic             illegal_instr,
    output logic             bus_error,
    output logic [CNT_W-1:0] retired
);

    localparam int              WAIT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_e             r_state;
    state_e             w_state_next;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic               r_illegal;
    logic               r_bus_error;
    logic [CNT_W-1:0]   r_retired;

    ctrl_t              w_dec_ctrl;
    ctrl_t              w_ctrl;
    logic               w_is_mem;
    logic               w_is_store;
    logic               w_illegal;
    logic               w_take_illegal;
    logic               w_timeout;

    mips_decoder u_decoder (
        .instruction (instruction),
        .zero        (zero),
        .ctrl        (w_dec_ctrl),
        .is_mem      (w_is_mem),
        .is_store    (w_is_store),
        .illegal     (w_illegal)
    );

    assign w_take_illegal = (r_state == ST_RUN) && imem_valid && w_illegal;
    // Ack in the final wait cycle still completes the access
    assign w_timeout      = (r_state == ST_MEM_WAIT) && !dmem_ack && (r_wait_cnt == WAIT_LAST);

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= ST_RUN;
        else       r_state <= w_state_next;
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_take_illegal)             w_state_next = ST_HALT;
                else if (imem_valid && w_is_mem) w_state_next = ST_MEM_WAIT;
            end
            ST_MEM_WAIT: begin
                if (dmem_ack)       w_state_next = ST_RUN;
                else if (w_timeout) w_state_next = ST_HALT;
            end
            ST_HALT:  w_state_next = ST_HALT;
            default:  w_state_next = ST_RUN;
        endcase
    end

    // Mealy outputs; write-back and PC advance are held back until commit
    always_comb begin
        w_ctrl   = CTRL_NOP;
        pc_en    = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        halted   = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (imem_valid && !w_illegal) begin
                    w_ctrl = w_dec_ctrl;
                    if (w_is_mem) begin
                        w_ctrl.rf_we = 1'b0;
                        dmem_req     = 1'b1;
                        dmem_we      = w_is_store;
                    end else begin
                        pc_en = 1'b1;
                    end
                end
            end
            ST_MEM_WAIT: begin
                w_ctrl   = w_dec_ctrl;
                dmem_req = 1'b1;
                dmem_we  = w_is_store;
                if (dmem_ack) pc_en = 1'b1;
                else          w_ctrl.rf_we = 1'b0;
            end
            ST_HALT: halted = 1'b1;
            default: ;
        endcase
    end

    // Wait counter, sticky halt causes and saturating retire counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wait_cnt  <= '0;
            r_illegal   <= 1'b0;
            r_bus_error <= 1'b0;
            r_retired   <= '0;
        end else begin
            if (r_state == ST_MEM_WAIT && !dmem_ack) r_wait_cnt <= r_wait_cnt + 1'b1;
            else                                     r_wait_cnt <= '0;
            if (w_take_illegal) r_illegal   <= 1'b1;
            if (w_timeout)      r_bus_error <= 1'b1;
            if (pc_en && (r_retired != {CNT_W{1'b1}})) r_retired <= r_retired + 1'b1;
        end
    end

    assign ctrl          = w_ctrl;
    assign illegal_instr = r_illegal;
    assign bus_error     = r_bus_error;
    assign retired       = r_retired;

endmodule

// File: tb/tb_mips_ctrl_fsm.sv
// Directed bench for mips_ctrl_fsm: expected outputs go into a scoreboard
// as each step is driven and are popped and compared mid-cycle.
module tb_mips_ctrl_fsm;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instruction = 32'h0;
    logic        imem_valid = 1'b0;
    logic        zero = 1'b0;
    logic        dmem_ack = 1'b0;
    logic [11:0] ctrl;
    logic        pc_en, dmem_req, dmem_we, halted, illegal_instr, bus_error;
    logic [31:0] retired;

    always #5 clock = ~clock;

    mips_ctrl_fsm #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clock         (clock),
        .reset         (reset),
        .instruction   (instruction),
        .imem_valid    (imem_valid),
        .zero          (zero),
        .dmem_ack      (dmem_ack),
        .ctrl          (ctrl),
        .pc_en         (pc_en),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .halted        (halted),
        .illegal_instr (illegal_instr),
        .bus_error     (bus_error),
        .retired       (retired)
    );

    localparam logic [31:0] I_ADD  = 32'h00221820;
    localparam logic [31:0] I_SUB  = 32'h00221822;
    localparam logic [31:0] I_OR   = 32'h00221825;
    localparam logic [31:0] I_XOR  = 32'h00221826;
    localparam logic [31:0] I_NOR  = 32'h00221827;
    localparam logic [31:0] I_SLT  = 32'h0022182A;
    localparam logic [31:0] I_SLL  = 32'h00011080;
    localparam logic [31:0] I_SRL  = 32'h00011082;
    localparam logic [31:0] I_JR   = 32'h03E00008;
    localparam logic [31:0] I_ADDI = 32'h20220005;
    localparam logic [31:0] I_ANDI = 32'h30220005;
    localparam logic [31:0] I_ORI  = 32'h34220005;
    localparam logic [31:0] I_SLTI = 32'h28220005;
    localparam logic [31:0] I_J    = 32'h08000010;
    localparam logic [31:0] I_JAL  = 32'h0C000010;
    localparam logic [31:0] I_BEQ  = 32'h1022FFFF;
    localparam logic [31:0] I_BNE  = 32'h1422FFFF;
    localparam logic [31:0] I_LW   = 32'h8C0A00FF;
    localparam logic [31:0] I_SW   = 32'hAC0A00FF;
    localparam logic [31:0] I_BADOP = 32'hFC000000;
    localparam logic [31:0] I_BADFN = 32'h0022183F;

    typedef struct {
        string       tag;
        logic [49:0] vec;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] model_ret = 32'd0;

    // Control word built from its fields in documented order
    function automatic logic [11:0] cw(input logic rf, input logic [1:0] wa, input logic ab,
                                       input logic [1:0] res, input logic [1:0] pc,
                                       input logic [3:0] alu);
        return {rf, wa, ab, res, pc, alu};
    endfunction

    task automatic expect_out(input string tag, input logic [11:0] c, input logic pe,
                              input logic rq, input logic we, input logic ht,
                              input logic il, input logic be);
        exp_t e;
        e.tag = tag;
        e.vec = {c, pe, rq, we, ht, il, be, model_ret};
        sb.push_back(e);
        if (pe) model_ret = model_ret + 32'd1;
    endtask

    task automatic check_out();
        exp_t        e;
        logic [49:0] act;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty observed=none expected=entry");
        end else begin
            e   = sb.pop_front();
            act = {ctrl, pc_en, dmem_req, dmem_we, halted, illegal_instr, bus_error, retired};
            $display("[%0t] %s ctrl=%h pe=%b req=%b we=%b halt=%b ill=%b berr=%b ret=%0d",
                     $time, e.tag, ctrl, pc_en, dmem_req, dmem_we, halted, illegal_instr,
                     bus_error, retired);
            assert (act === e.vec)
            else begin
                bad++;
                $error("FAIL %s observed=%h expected=%h (ctrl %h want %h, retired %0d want %0d)",
                       e.tag, act, e.vec, act[49:38], e.vec[49:38], act[31:0], e.vec[31:0]);
            end
        end
    endtask

    task automatic step(input logic [31:0] ins, input logic v, input logic z, input logic a,
                        input string tag, input logic [11:0] c, input logic pe,
                        input logic rq, input logic we, input logic ht,
                        input logic il, input logic be);
        @(negedge clock);
        instruction = ins;
        imem_valid  = v;
        zero        = z;
        dmem_ack    = a;
        #1;
        expect_out(tag, c, pe, rq, we, ht, il, be);
        check_out();
    endtask

    task automatic reset_pulse();
        @(negedge clock);
        reset      = 1'b1;
        imem_valid = 1'b0;
        dmem_ack   = 1'b0;
        model_ret  = 32'd0;
        #1;
        expect_out("reset_pulse", 12'h000, 0, 0, 0, 0, 0, 0);
        check_out();
        #2 reset = 1'b0;
    endtask

    initial begin
        logic [11:0] c_lw_wait;
        logic [11:0] c_lw_done;
        logic [11:0] c_sw;
        c_lw_wait = cw(1'b0, 2'b00, 1'b1, 2'b01, 2'b00, 4'd0);
        c_lw_done = cw(1'b1, 2'b00, 1'b1, 2'b01, 2'b00, 4'd0);
        c_sw      = cw(1'b0, 2'b00, 1'b1, 2'b00, 2'b00, 4'd0);

        #1;
        expect_out("reset", 12'h000, 0, 0, 0, 0, 0, 0);
        check_out();
        #2 reset = 1'b0;

        // Non-memory instructions commit the same cycle
        step(I_ADD, 0, 0, 0, "idle",  12'h000, 0, 0, 0, 0, 0, 0);
        step(I_ADD, 1, 0, 0, "add",   cw(1, 2'b01, 0, 2'b00, 2'b00, 4'd0), 1, 0, 0, 0, 0, 0);
        step(I_ADD, 0, 0, 0, "ret1",  12'h000, 0, 0, 0, 0, 0, 0);
        step(I_SUB, 1, 0, 0, "sub",   cw(1, 2'b01, 0, 2'b00, 2'b00, 4'd1), 1, 0, 0, 0, 0, 0);
        step(I_OR,  1, 0, 0, "or",    cw(1, 2'b01, 0, 2'b00, 2'b00, 4'd3), 1, 0, 0, 0, 0, 0);
        step(I_XOR, 1, 0, 0, "xor",   cw(1, 2'b01, 0, 2'b00, 2'b00, 4'd4), 1, 0, 0, 0, 0, 0);
        step(I_NOR, 1, 0, 0, "nor",   cw(1, 2'b01, 0, 2'b00, 2'b00, 4'd5), 1, 0, 0, 0, 0, 0);
        step(I_SLT, 1, 0, 0, "slt",   cw(1, 2'b01, 0, 2'b00, 2'b00, 4'd6), 1, 0, 0, 0, 0, 0);
        step(I_SLL, 1, 0, 0, "sll",   cw(1, 2'b01, 0, 2'b00, 2'b00, 4'd7), 1, 0, 0, 0, 0, 0);
        step(I_SRL, 1, 0, 0, "srl",   cw(1, 2'b01, 0, 2'b00, 2'b00, 4'd8), 1, 0, 0, 0, 0, 0);
        step(I_JR,  1, 0, 0, "jr",    cw(0, 2'b00, 0, 2'b00, 2'b11, 4'd0), 1, 0, 0, 0, 0, 0);
        step(I_ADDI,1, 0, 0, "addi",  cw(1, 2'b00, 1, 2'b00, 2'b00, 4'd0), 1, 0, 0, 0, 0, 0);
        step(I_ANDI,1, 0, 0, "andi",  cw(1, 2'b00, 1, 2'b00, 2'b00, 4'd2), 1, 0, 0, 0, 0, 0);
        step(I_ORI, 1, 0, 0, "ori",   cw(1, 2'b00, 1, 2'b00, 2'b00, 4'd3), 1, 0, 0, 0, 0, 0);
        step(I_SLTI,1, 0, 0, "slti",  cw(1, 2'b00, 1, 2'b00, 2'b00, 4'd6), 1, 0, 0, 0, 0, 0);
        step(I_J,   1, 0, 0, "j",     cw(0, 2'b00, 0, 2'b00, 2'b10, 4'd0), 1, 0, 0, 0, 0, 0);
        step(I_JAL, 1, 0, 0, "jal",   cw(1, 2'b10, 0, 2'b10, 2'b10, 4'd0), 1, 0, 0, 0, 0, 0);

        // Branches: target select follows zero
        step(I_BEQ, 1, 1, 0, "beq_taken", cw(0, 2'b00, 0, 2'b00, 2'b01, 4'd1), 1, 0, 0, 0, 0, 0);
        step(I_BEQ, 1, 0, 0, "beq_not",   cw(0, 2'b00, 0, 2'b00, 2'b00, 4'd1), 1, 0, 0, 0, 0, 0);
        step(I_BNE, 1, 0, 0, "bne_taken", cw(0, 2'b00, 0, 2'b00, 2'b01, 4'd1), 1, 0, 0, 0, 0, 0);
        step(I_BNE, 1, 1, 0, "bne_not",   cw(0, 2'b00, 0, 2'b00, 2'b00, 4'd1), 1, 0, 0, 0, 0, 0);

        // lw with ack three cycles after the request; ack in RUN is ignored
        step(I_LW, 1, 0, 1, "lw_req",   c_lw_wait, 0, 1, 0, 0, 0, 0);
        step(I_LW, 1, 0, 0, "lw_wait1", c_lw_wait, 0, 1, 0, 0, 0, 0);
        step(I_LW, 1, 0, 0, "lw_wait2", c_lw_wait, 0, 1, 0, 0, 0, 0);
        step(I_LW, 1, 0, 1, "lw_ack",   c_lw_done, 1, 1, 0, 0, 0, 0);
        step(I_LW, 0, 0, 0, "lw_after", 12'h000, 0, 0, 0, 0, 0, 0);

        // sw with single-cycle latency
        step(I_SW, 1, 0, 0, "sw_req", c_sw, 0, 1, 1, 0, 0, 0);
        step(I_SW, 1, 0, 1, "sw_ack", c_sw, 1, 1, 1, 0, 0, 0);
        step(I_SW, 0, 0, 0, "sw_after", 12'h000, 0, 0, 0, 0, 0, 0);

        // Ack on the last allowed wait cycle beats the timeout
        step(I_LW, 1, 0, 0, "edge_req", c_lw_wait, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            step(I_LW, 1, 0, 0, "edge_wait", c_lw_wait, 0, 1, 0, 0, 0, 0);
        step(I_LW, 1, 0, 1, "edge_ack", c_lw_done, 1, 1, 0, 0, 0, 0);
        step(I_ADD, 0, 0, 0, "edge_after", 12'h000, 0, 0, 0, 0, 0, 0);

        // Asynchronous reset mid-MEM_WAIT, off a clock edge
        step(I_LW, 1, 0, 0, "rst_req",  c_lw_wait, 0, 1, 0, 0, 0, 0);
        step(I_LW, 1, 0, 0, "rst_wait", c_lw_wait, 0, 1, 0, 0, 0, 0);
        #2;
        reset      = 1'b1;
        imem_valid = 1'b0;
        model_ret  = 32'd0;
        #1;
        expect_out("rst_async", 12'h000, 0, 0, 0, 0, 0, 0);
        check_out();
        #3 reset = 1'b0;
        step(I_LW, 1, 0, 0, "post_rst_req", c_lw_wait, 0, 1, 0, 0, 0, 0);
        step(I_LW, 1, 0, 1, "post_rst_ack", c_lw_done, 1, 1, 0, 0, 0, 0);
        step(I_LW, 0, 0, 0, "post_rst_ret", 12'h000, 0, 0, 0, 0, 0, 0);

        // Timeout: four wait cycles without ack end in bus error
        step(I_LW, 1, 0, 0, "to_req", c_lw_wait, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            step(I_LW, 1, 0, 0, "to_wait", c_lw_wait, 0, 1, 0, 0, 0, 0);
        step(I_LW, 1, 0, 1, "to_halt", 12'h000, 0, 0, 0, 1, 0, 1);
        step(I_ADD, 1, 0, 0, "to_hold", 12'h000, 0, 0, 0, 1, 0, 1);

        // Illegal opcode halts and stays halted
        reset_pulse();
        step(I_BADOP, 1, 0, 0, "ill_op", 12'h000, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++)
            step(I_ADD, 1, 0, 1, "ill_hold", 12'h000, 0, 0, 0, 1, 1, 0);

        // Illegal R-type funct
        reset_pulse();
        step(I_BADFN, 1, 0, 0, "ill_fn", 12'h000, 0, 0, 0, 0, 0, 0);
        step(I_ADD,   1, 0, 0, "ill_fn_halt", 12'h000, 0, 0, 0, 1, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
